// File: rtl/matrix_bank_if.sv
// Bus bundle between matrix_bank_ctrl and its users (input/display path and matrix ALU).
// The master modport is the requesting side; the slave modport is the bank itself.
interface matrix_bank_if #(
  parameter int DATA_W    = 16,
  parameter int DIM_W     = 3,
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_W    = 2
);
  logic [SLOT_W-1:0]    user_slot;
  logic [DIM_W-1:0]     user_row, user_col;
  logic [DATA_W-1:0]    user_wdata;
  logic                 user_we, user_re;
  logic [DIM_W-1:0]     user_dim_m, user_dim_n;
  logic                 user_dim_we;
  logic [DATA_W-1:0]    user_rdata;
  logic                 user_rvalid;
  logic [SLOT_W-1:0]    alu_rd_slot;
  logic [DIM_W-1:0]     alu_rd_row, alu_rd_col;
  logic                 alu_re;
  logic [DATA_W-1:0]    alu_rdata;
  logic                 alu_rvalid;
  logic [DIM_W-1:0]     alu_cur_m, alu_cur_n;
  logic [SLOT_W-1:0]    alu_wr_slot;
  logic [DIM_W-1:0]     alu_wr_row, alu_wr_col;
  logic [DATA_W-1:0]    alu_wdata;
  logic                 alu_we;
  logic [DIM_W-1:0]     alu_res_m, alu_res_n;
  logic                 alu_dim_we;
  logic                 clr_req;
  logic [SLOT_W-1:0]    clr_slot;
  logic                 clr_busy, clr_done;
  logic [NUM_SLOTS-1:0] slot_valid;
  logic                 wr_conflict, err;

  modport master (
    output user_slot, user_row, user_col, user_wdata, user_we, user_re,
           user_dim_m, user_dim_n, user_dim_we,
           alu_rd_slot, alu_rd_row, alu_rd_col, alu_re,
           alu_wr_slot, alu_wr_row, alu_wr_col, alu_wdata, alu_we,
           alu_res_m, alu_res_n, alu_dim_we, clr_req, clr_slot,
    input  user_rdata, user_rvalid, alu_rdata, alu_rvalid, alu_cur_m, alu_cur_n,
           clr_busy, clr_done, slot_valid, wr_conflict, err
  );

  modport slave (
    input  user_slot, user_row, user_col, user_wdata, user_we, user_re,
           user_dim_m, user_dim_n, user_dim_we,
           alu_rd_slot, alu_rd_row, alu_rd_col, alu_re,
           alu_wr_slot, alu_wr_row, alu_wr_col, alu_wdata, alu_we,
           alu_res_m, alu_res_n, alu_dim_we, clr_req, clr_slot,
    output user_rdata, user_rvalid, alu_rdata, alu_rvalid, alu_cur_m, alu_cur_n,
           clr_busy, clr_done, slot_valid, wr_conflict, err
  );
endinterface

// File: rtl/matrix_bank_ctrl.sv
// Multi-slot matrix store with registered reads, per-slot dims/valid, range checks
// and a background engine that zeroes one slot while the others stay usable.
module matrix_bank_ctrl #(
  parameter int DATA_W    = 16,
  parameter int DIM_W     = 3,
  parameter int MAX_DIM   = 5,
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_W    = 2,
  parameter int RES_SLOT  = 2
) (
  input logic          clk,
  input logic          rst,
  matrix_bank_if.slave bus
);
  localparam int AREA  = MAX_DIM * MAX_DIM;
  localparam int DEPTH = NUM_SLOTS * AREA;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(AREA);

  typedef enum logic {IDLE, CLEAR} state_t;

  function automatic logic slot_ok(input logic [SLOT_W-1:0] s);
    return int'(s) < NUM_SLOTS;
  endfunction

  function automatic logic coord_ok(input logic [SLOT_W-1:0] s, input logic [DIM_W-1:0] r,
                                    input logic [DIM_W-1:0] c);
    return slot_ok(s) && (int'(r) < MAX_DIM) && (int'(c) < MAX_DIM);
  endfunction

  function automatic logic dims_ok(input logic [DIM_W-1:0] m, input logic [DIM_W-1:0] n);
    return (m != '0) && (n != '0) && (int'(m) <= MAX_DIM) && (int'(n) <= MAX_DIM);
  endfunction

  function automatic logic [AW-1:0] addr_of(input logic [SLOT_W-1:0] s, input logic [DIM_W-1:0] r,
                                            input logic [DIM_W-1:0] c);
    return AW'(int'(s) * AREA + int'(r) * MAX_DIM + int'(c));
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_reg;
  logic [SLOT_W-1:0] clr_slot_reg;
  logic [CW-1:0]     cnt_reg;
  logic              clr_busy_reg, clr_done_reg;
  logic [DATA_W-1:0] user_rdata_reg, alu_rdata_reg;
  logic              user_rvalid_reg, alu_rvalid_reg;
  logic              err_reg, conflict_reg;
  logic [DIM_W-1:0]  dim_m [NUM_SLOTS];
  logic [DIM_W-1:0]  dim_n [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] valid;

  logic          clearing, clr_last, user_blk, alu_blk, res_blk;
  logic [AW-1:0] user_addr, alu_wr_addr, alu_rd_addr, clr_addr;
  logic          user_wr_ok, alu_wr_ok, conflict, user_wr_eff;
  logic          user_dim_bad, user_dim_ok, alu_dim_ok, err_next;

  assign clearing = (state_reg == CLEAR);
  assign clr_last = clearing && (cnt_reg == CW'(AREA - 1));
  // Writes aimed at the slot being cleared are refused for the whole clear.
  assign user_blk = clearing && (bus.user_slot == clr_slot_reg);
  assign alu_blk  = clearing && (bus.alu_wr_slot == clr_slot_reg);
  assign res_blk  = clearing && (clr_slot_reg == SLOT_W'(RES_SLOT));

  assign user_addr   = addr_of(bus.user_slot, bus.user_row, bus.user_col);
  assign alu_wr_addr = addr_of(bus.alu_wr_slot, bus.alu_wr_row, bus.alu_wr_col);
  assign alu_rd_addr = addr_of(bus.alu_rd_slot, bus.alu_rd_row, bus.alu_rd_col);
  assign clr_addr    = AW'(int'(clr_slot_reg) * AREA + int'(cnt_reg));

  assign user_wr_ok  = bus.user_we && coord_ok(bus.user_slot, bus.user_row, bus.user_col) && !user_blk;
  assign alu_wr_ok   = bus.alu_we && coord_ok(bus.alu_wr_slot, bus.alu_wr_row, bus.alu_wr_col) && !alu_blk;
  assign conflict    = user_wr_ok && alu_wr_ok && (user_addr == alu_wr_addr);
  assign user_wr_eff = user_wr_ok && !conflict;

  assign alu_dim_ok   = bus.alu_dim_we && dims_ok(bus.alu_res_m, bus.alu_res_n) && !res_blk;
  assign user_dim_bad = !dims_ok(bus.user_dim_m, bus.user_dim_n) || !slot_ok(bus.user_slot) || user_blk;
  // A user dims write to the result slot yields silently to a same-cycle ALU dims write.
  assign user_dim_ok  = bus.user_dim_we && !user_dim_bad &&
                        !(bus.alu_dim_we && (bus.user_slot == SLOT_W'(RES_SLOT)));

  assign err_next = (bus.user_we && !user_wr_ok) || (bus.alu_we && !alu_wr_ok) || conflict ||
                    (bus.user_dim_we && user_dim_bad) || (bus.alu_dim_we && !alu_dim_ok) ||
                    (bus.clr_req && !clearing && !slot_ok(bus.clr_slot));

  always_ff @(posedge clk) begin
    if (user_wr_eff) mem[user_addr] <= bus.user_wdata;
    if (alu_wr_ok)   mem[alu_wr_addr] <= bus.alu_wdata;
    if (clearing)    mem[clr_addr] <= '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      user_rdata_reg  <= '0;
      user_rvalid_reg <= 1'b0;
      alu_rdata_reg   <= '0;
      alu_rvalid_reg  <= 1'b0;
      err_reg         <= 1'b0;
      conflict_reg    <= 1'b0;
    end else begin
      user_rvalid_reg <= bus.user_re;
      alu_rvalid_reg  <= bus.alu_re;
      if (bus.user_re)
        user_rdata_reg <= coord_ok(bus.user_slot, bus.user_row, bus.user_col) ? mem[user_addr] : '0;
      if (bus.alu_re)
        alu_rdata_reg <= coord_ok(bus.alu_rd_slot, bus.alu_rd_row, bus.alu_rd_col) ? mem[alu_rd_addr] : '0;
      err_reg      <= err_next;
      conflict_reg <= conflict;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      clr_slot_reg <= '0;
      cnt_reg      <= '0;
      clr_busy_reg <= 1'b0;
      clr_done_reg <= 1'b0;
    end else begin
      clr_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.clr_req && slot_ok(bus.clr_slot)) begin
            clr_slot_reg <= bus.clr_slot;
            cnt_reg      <= '0;
            clr_busy_reg <= 1'b1;
            state_reg    <= CLEAR;
          end
        end
        CLEAR: begin
          if (clr_last) begin
            cnt_reg      <= '0;
            clr_busy_reg <= 1'b0;
            clr_done_reg <= 1'b1;
            state_reg    <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    localparam bit IS_RES = (gi == RES_SLOT);
    logic [DIM_W-1:0] m_reg, n_reg;
    logic             v_reg;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        m_reg <= '0;
        n_reg <= '0;
        v_reg <= 1'b0;
      end else if (clr_last && (clr_slot_reg == SLOT_W'(gi))) begin
        m_reg <= '0;
        n_reg <= '0;
        v_reg <= 1'b0;
      end else if (IS_RES && alu_dim_ok) begin
        m_reg <= bus.alu_res_m;
        n_reg <= bus.alu_res_n;
        v_reg <= 1'b1;
      end else if (user_dim_ok && (bus.user_slot == SLOT_W'(gi))) begin
        m_reg <= bus.user_dim_m;
        n_reg <= bus.user_dim_n;
        v_reg <= 1'b1;
      end
    end

    assign dim_m[gi] = m_reg;
    assign dim_n[gi] = n_reg;
    assign valid[gi] = v_reg;
  end

  assign bus.alu_cur_m   = slot_ok(bus.alu_rd_slot) ? dim_m[bus.alu_rd_slot] : '0;
  assign bus.alu_cur_n   = slot_ok(bus.alu_rd_slot) ? dim_n[bus.alu_rd_slot] : '0;
  assign bus.user_rdata  = user_rdata_reg;
  assign bus.user_rvalid = user_rvalid_reg;
  assign bus.alu_rdata   = alu_rdata_reg;
  assign bus.alu_rvalid  = alu_rvalid_reg;
  assign bus.clr_busy    = clr_busy_reg;
  assign bus.clr_done    = clr_done_reg;
  assign bus.slot_valid  = valid;
  assign bus.wr_conflict = conflict_reg;
  assign bus.err         = err_reg;
endmodule

// File: tb/tb_matrix_bank_ctrl.sv
// Bench for matrix_bank_ctrl: directed vector table, hand-written clear/conflict/reset
// sequences, then randomized traffic against a slot/row/col array model.
module tb_matrix_bank_ctrl;
  localparam int DW = 16, DIMW = 3, MD = 5, NS = 4, SW = 2, RS = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matrix_bank_if #(.DATA_W(DW), .DIM_W(DIMW), .NUM_SLOTS(NS), .SLOT_W(SW)) bus ();

  matrix_bank_ctrl #(.DATA_W(DW), .DIM_W(DIMW), .MAX_DIM(MD), .NUM_SLOTS(NS),
                     .SLOT_W(SW), .RES_SLOT(RS)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          kind;   // 0 element write, 1 read, 2 dims write
    int          s, r, c;
    logic [15:0] d;
    int          m, n;
    logic        exp_err, exp_rv;
    logic [15:0] exp_rd;
    string       name;
  } vec_t;

  vec_t tbl[10];

  // Reference model state
  logic [15:0] mm [NS][MD][MD];
  int          md_m[NS], md_n[NS];
  logic [3:0]  mvalid;
  bit          mact, mdone, merr, mconf, m_urv, m_arv;
  int          mslot, midx;
  logic [15:0] m_urd, m_ard;

  function automatic vec_t mk(input int kind, s, r, c, input logic [15:0] d, input int m, n,
                              input logic e, rv, input logic [15:0] rd, input string nm);
    vec_t v;
    v.kind = kind; v.s = s; v.r = r; v.c = c; v.d = d; v.m = m; v.n = n;
    v.exp_err = e; v.exp_rv = rv; v.exp_rd = rd; v.name = nm;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.user_slot = '0; bus.user_row = '0; bus.user_col = '0; bus.user_wdata = '0;
    bus.user_we = 1'b0; bus.user_re = 1'b0; bus.user_dim_m = '0; bus.user_dim_n = '0;
    bus.user_dim_we = 1'b0; bus.alu_rd_slot = '0; bus.alu_rd_row = '0; bus.alu_rd_col = '0;
    bus.alu_re = 1'b0; bus.alu_wr_slot = '0; bus.alu_wr_row = '0; bus.alu_wr_col = '0;
    bus.alu_wdata = '0; bus.alu_we = 1'b0; bus.alu_res_m = '0; bus.alu_res_n = '0;
    bus.alu_dim_we = 1'b0; bus.clr_req = 1'b0; bus.clr_slot = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_user(input int s, r, c);
    bus.user_slot = SW'(s); bus.user_row = DIMW'(r); bus.user_col = DIMW'(c);
  endtask

  task automatic uwrite(input int s, r, c, input logic [15:0] d);
    set_user(s, r, c); bus.user_wdata = d; bus.user_we = 1'b1;
  endtask

  task automatic awrite(input int s, r, c, input logic [15:0] d);
    bus.alu_wr_slot = SW'(s); bus.alu_wr_row = DIMW'(r); bus.alu_wr_col = DIMW'(c);
    bus.alu_wdata = d; bus.alu_we = 1'b1;
  endtask

  task automatic aread(input int s, r, c);
    bus.alu_rd_slot = SW'(s); bus.alu_rd_row = DIMW'(r); bus.alu_rd_col = DIMW'(c);
    bus.alu_re = 1'b1;
  endtask

  task automatic udims(input int s, m, n);
    bus.user_slot = SW'(s); bus.user_dim_m = DIMW'(m); bus.user_dim_n = DIMW'(n);
    bus.user_dim_we = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  function automatic bit legal(input int m, input int n);
    return (m >= 1) && (m <= MD) && (n >= 1) && (n <= MD);
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_user_rdata"}, 32'(bus.user_rdata), 0);
    chk({tag, "_user_rvalid"}, 32'(bus.user_rvalid), 0);
    chk({tag, "_alu_rdata"}, 32'(bus.alu_rdata), 0);
    chk({tag, "_alu_rvalid"}, 32'(bus.alu_rvalid), 0);
    chk({tag, "_clr_busy"}, 32'(bus.clr_busy), 0);
    chk({tag, "_clr_done"}, 32'(bus.clr_done), 0);
    chk({tag, "_slot_valid"}, 32'(bus.slot_valid), 0);
    chk({tag, "_wr_conflict"}, 32'(bus.wr_conflict), 0);
    chk({tag, "_err"}, 32'(bus.err), 0);
    chk({tag, "_cur_m"}, 32'(bus.alu_cur_m), 0);
    chk({tag, "_cur_n"}, 32'(bus.alu_cur_n), 0);
  endtask

  initial begin
    int n, guard;
    logic exp_e;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    bus.alu_rd_slot = SW'(1);
    #1;
    check_all_zero("reset");

    // ---------------- directed vector table ----------------
    tbl[0] = mk(2, 1, 0, 0, 16'h0, 3, 4, 0, 0, 16'h0, "dims_s1_3x4");
    tbl[1] = mk(2, 0, 0, 0, 16'h0, 0, 2, 1, 0, 16'h0, "dims_0x2_rej");
    tbl[2] = mk(2, 0, 0, 0, 16'h0, 6, 1, 1, 0, 16'h0, "dims_6x1_rej");
    tbl[3] = mk(0, 0, 2, 3, 16'h1234, 0, 0, 0, 0, 16'h0, "wr_023");
    tbl[4] = mk(1, 0, 2, 3, 16'h0, 0, 0, 0, 1, 16'h1234, "rd_023");
    tbl[5] = mk(1, 0, 5, 0, 16'h0, 0, 0, 0, 1, 16'h0000, "rd_row5");
    tbl[6] = mk(0, 0, 3, 0, 16'h0303, 0, 0, 0, 0, 16'h0, "wr_030");
    tbl[7] = mk(0, 0, 2, 5, 16'hBEEF, 0, 0, 1, 0, 16'h0, "wr_col5_rej");
    tbl[8] = mk(1, 0, 3, 0, 16'h0, 0, 0, 0, 1, 16'h0303, "rd_030_kept");
    tbl[9] = mk(1, 0, 2, 3, 16'h0, 0, 0, 0, 1, 16'h1234, "rd_023_kept");
    for (int i = 0; i < 10; i++) begin
      idle();
      case (tbl[i].kind)
        0: uwrite(tbl[i].s, tbl[i].r, tbl[i].c, tbl[i].d);
        1: begin set_user(tbl[i].s, tbl[i].r, tbl[i].c); bus.user_re = 1'b1; end
        default: udims(tbl[i].s, tbl[i].m, tbl[i].n);
      endcase
      tick();
      idle();
      chk({tbl[i].name, "_err"}, 32'(bus.err), 32'(tbl[i].exp_err));
      chk({tbl[i].name, "_rvalid"}, 32'(bus.user_rvalid), 32'(tbl[i].exp_rv));
      if (tbl[i].kind == 1) chk({tbl[i].name, "_rdata"}, 32'(bus.user_rdata), 32'(tbl[i].exp_rd));
    end
    chk("slot_valid_after_dims", 32'(bus.slot_valid), 32'h2);
    bus.alu_rd_slot = SW'(1); #1;
    chk("cur_m_s1", 32'(bus.alu_cur_m), 3);
    chk("cur_n_s1", 32'(bus.alu_cur_n), 4);
    bus.alu_rd_slot = SW'(0); #1;
    chk("cur_m_s0", 32'(bus.alu_cur_m), 0);

    // ---------------- read-first and rdata hold ----------------
    uwrite(1, 0, 0, 16'hAAAA); tick(); idle();
    uwrite(1, 0, 0, 16'hBBBB); bus.user_re = 1'b1; tick(); idle();
    chk("rdw_old_data", 32'(bus.user_rdata), 32'hAAAA);
    set_user(1, 0, 0); bus.user_re = 1'b1; tick(); idle();
    chk("rdw_new_data", 32'(bus.user_rdata), 32'hBBBB);
    tick();
    chk("hold_rvalid", 32'(bus.user_rvalid), 0);
    chk("hold_rdata", 32'(bus.user_rdata), 32'hBBBB);

    // ---------------- write conflicts ----------------
    uwrite(2, 1, 1, 16'hAAAA); awrite(2, 1, 1, 16'h5555); tick(); idle();
    chk("conf_wr_conflict", 32'(bus.wr_conflict), 1);
    chk("conf_err", 32'(bus.err), 1);
    aread(2, 1, 1); tick(); idle();
    chk("conf_pulse_end", 32'(bus.wr_conflict), 0);
    chk("conf_alu_rvalid", 32'(bus.alu_rvalid), 1);
    chk("conf_readback", 32'(bus.alu_rdata), 32'h5555);
    uwrite(2, 0, 0, 16'h1111); awrite(2, 0, 1, 16'h2222); tick(); idle();
    chk("diff_err", 32'(bus.err), 0);
    chk("diff_conflict", 32'(bus.wr_conflict), 0);
    set_user(2, 0, 0); bus.user_re = 1'b1; aread(2, 0, 1); tick(); idle();
    chk("diff_user_rd", 32'(bus.user_rdata), 32'h1111);
    chk("diff_alu_rd", 32'(bus.alu_rdata), 32'h2222);

    // ---------------- background clear of slot 2 ----------------
    udims(2, 3, 3); tick(); idle();
    chk("clr_pre_valid", 32'(bus.slot_valid), 32'h6);
    for (int i = 0; i < MD * MD; i++) begin
      uwrite(2, i / MD, i % MD, 16'(16'h100 + i)); tick(); idle();
    end
    bus.clr_req = 1'b1; bus.clr_slot = SW'(2); tick(); idle();
    chk("clr_busy_start", 32'(bus.clr_busy), 1);
    n = 0; guard = 0;
    while (bus.clr_busy && guard < 100) begin
      n++; guard++;
      exp_e = 1'b0;
      case (n)
        3:  begin uwrite(2, 1, 1, 16'hFFFF); exp_e = 1'b1; end
        5:  uwrite(0, 0, 0, 16'h7777);
        7:  begin bus.clr_req = 1'b1; bus.clr_slot = SW'(0); end
        9:  begin awrite(2, 4, 4, 16'hFFFF); exp_e = 1'b1; end
        11: begin udims(2, 2, 2); exp_e = 1'b1; end
        13: begin set_user(2, 4, 4); bus.user_re = 1'b1; end
        default: ;
      endcase
      tick(); idle();
      if (n == 3 || n == 5 || n == 7 || n == 9 || n == 11) chk($sformatf("clr_err_c%0d", n), 32'(bus.err), 32'(exp_e));
      if (n == 13) chk("clr_rd_live", 32'(bus.user_rdata), 32'h118);
    end
    chk("clr_busy_cycles", n, MD * MD);
    chk("clr_done_pulse", 32'(bus.clr_done), 1);
    tick();
    chk("clr_done_end", 32'(bus.clr_done), 0);
    chk("clr_second_ignored", 32'(bus.clr_busy), 0);
    for (int i = 0; i < MD * MD; i++) begin
      set_user(2, i / MD, i % MD); bus.user_re = 1'b1; tick(); idle();
      chk($sformatf("clr_zero_%0d", i), 32'(bus.user_rdata), 0);
    end
    chk("clr_valid_bit", 32'(bus.slot_valid), 32'h2);
    bus.alu_rd_slot = SW'(2); #1;
    chk("clr_dims_m", 32'(bus.alu_cur_m), 0);
    set_user(0, 0, 0); bus.user_re = 1'b1; tick(); idle();
    chk("clr_other_slot_wr", 32'(bus.user_rdata), 32'h7777);
    set_user(0, 2, 3); bus.user_re = 1'b1; tick(); idle();
    chk("clr_slot0_intact", 32'(bus.user_rdata), 32'h1234);

    // ---------------- simultaneous dims to the result slot ----------------
    udims(RS, 4, 4); bus.alu_res_m = 3'd2; bus.alu_res_n = 3'd2; bus.alu_dim_we = 1'b1;
    tick(); idle();
    bus.alu_rd_slot = SW'(RS); #1;
    chk("dimrace_m", 32'(bus.alu_cur_m), 2);
    chk("dimrace_n", 32'(bus.alu_cur_n), 2);
    chk("dimrace_valid", 32'(bus.slot_valid), 32'h6);
    udims(0, 4, 4); bus.alu_res_m = 3'd1; bus.alu_res_n = 3'd5; bus.alu_dim_we = 1'b1;
    tick(); idle();
    chk("dim_both_valid", 32'(bus.slot_valid), 32'h7);

    // ---------------- reset in the middle of a clear ----------------
    bus.clr_req = 1'b1; bus.clr_slot = SW'(1); tick(); idle();
    repeat (9) tick();
    chk("mid_busy", 32'(bus.clr_busy), 1);
    set_user(1, 0, 0); bus.user_re = 1'b1; tick(); idle();
    #2 rst = 1'b1;
    #1;
    bus.alu_rd_slot = SW'(1); #1;
    check_all_zero("midrst");
    #2 rst = 1'b0;
    tick();
    chk("midrst_stays_idle", 32'(bus.clr_busy), 0);

    // ---------------- randomized traffic against the model ----------------
    do_reset();
    for (int s = 0; s < NS; s++) begin
      md_m[s] = 0; md_n[s] = 0;
      for (int r = 0; r < MD; r++)
        for (int c = 0; c < MD; c++) begin
          mm[s][r][c] = 16'($urandom);
          uwrite(s, r, c, mm[s][r][c]); tick(); idle();
        end
    end
    mvalid = '0; mact = 0; mdone = 0; m_urd = '0; m_ard = '0;
    for (int t = 0; t < 400; t++) begin
      int us, ur, uc, aws, awr, awc, ars, arr, arc, udm, udn, arm, arn, cs;
      bit uwe, awe, ure, are, udwe, adwe, creq, ublk, ablk, u_ok, a_ok;
      logic [15:0] ud, ad;
      us = $urandom_range(0, NS - 1);
      ur = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
      uc = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
      if ($urandom_range(0, 3) == 0) begin aws = us; awr = ur; awc = uc; end
      else begin
        aws = $urandom_range(0, NS - 1);
        awr = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
        awc = $urandom_range(0, 4);
      end
      ars = $urandom_range(0, NS - 1);
      arr = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
      arc = $urandom_range(0, 4);
      udm = $urandom_range(0, 7); udn = $urandom_range(0, 7);
      arm = $urandom_range(0, 7); arn = $urandom_range(0, 7);
      cs  = $urandom_range(0, NS - 1);
      ud = 16'($urandom); ad = 16'($urandom);
      uwe = ($urandom_range(0, 1) == 0); awe = ($urandom_range(0, 2) == 0);
      ure = ($urandom_range(0, 1) == 0); are = ($urandom_range(0, 1) == 0);
      udwe = ($urandom_range(0, 9) == 0); adwe = ($urandom_range(0, 9) == 0);
      creq = ($urandom_range(0, 29) == 0);

      set_user(us, ur, uc); bus.user_wdata = ud; bus.user_we = uwe; bus.user_re = ure;
      bus.user_dim_m = DIMW'(udm); bus.user_dim_n = DIMW'(udn); bus.user_dim_we = udwe;
      bus.alu_wr_slot = SW'(aws); bus.alu_wr_row = DIMW'(awr); bus.alu_wr_col = DIMW'(awc);
      bus.alu_wdata = ad; bus.alu_we = awe;
      bus.alu_rd_slot = SW'(ars); bus.alu_rd_row = DIMW'(arr); bus.alu_rd_col = DIMW'(arc);
      bus.alu_re = are;
      bus.alu_res_m = DIMW'(arm); bus.alu_res_n = DIMW'(arn); bus.alu_dim_we = adwe;
      bus.clr_req = creq; bus.clr_slot = SW'(cs);

      // model: effect of the coming clock edge
      ublk = mact && (us == mslot);
      ablk = mact && (aws == mslot);
      u_ok = uwe && ur < MD && uc < MD && !ublk;
      a_ok = awe && awr < MD && awc < MD && !ablk;
      mconf = u_ok && a_ok && us == aws && ur == awr && uc == awc;
      merr = (uwe && !u_ok) || (awe && !a_ok) || mconf;
      m_urv = ure; m_arv = are;
      if (ure) m_urd = (ur < MD && uc < MD) ? mm[us][ur][uc] : 16'h0;
      if (are) m_ard = (arr < MD && arc < MD) ? mm[ars][arr][arc] : 16'h0;
      if (u_ok && !mconf) mm[us][ur][uc] = ud;
      if (a_ok) mm[aws][awr][awc] = ad;
      if (adwe) begin
        if (legal(arm, arn) && !(mact && mslot == RS)) begin
          md_m[RS] = arm; md_n[RS] = arn; mvalid[RS] = 1'b1;
        end else merr = 1;
      end
      if (udwe) begin
        if (!legal(udm, udn) || ublk) merr = 1;
        else if (!(adwe && us == RS)) begin
          md_m[us] = udm; md_n[us] = udn; mvalid[us] = 1'b1;
        end
      end
      mdone = 0;
      if (mact) begin
        mm[mslot][midx / MD][midx % MD] = 16'h0;
        midx++;
        if (midx == MD * MD) begin
          md_m[mslot] = 0; md_n[mslot] = 0; mvalid[mslot] = 1'b0; mact = 0; mdone = 1;
        end
      end else if (creq) begin
        mact = 1; mslot = cs; midx = 0;
      end

      tick();
      chk($sformatf("rnd%0d_err", t), 32'(bus.err), 32'(merr));
      chk($sformatf("rnd%0d_conflict", t), 32'(bus.wr_conflict), 32'(mconf));
      chk($sformatf("rnd%0d_urv", t), 32'(bus.user_rvalid), 32'(m_urv));
      chk($sformatf("rnd%0d_urd", t), 32'(bus.user_rdata), 32'(m_urd));
      chk($sformatf("rnd%0d_arv", t), 32'(bus.alu_rvalid), 32'(m_arv));
      chk($sformatf("rnd%0d_ard", t), 32'(bus.alu_rdata), 32'(m_ard));
      chk($sformatf("rnd%0d_busy", t), 32'(bus.clr_busy), 32'(mact));
      chk($sformatf("rnd%0d_done", t), 32'(bus.clr_done), 32'(mdone));
      chk($sformatf("rnd%0d_valid", t), 32'(bus.slot_valid), 32'(mvalid));
      chk($sformatf("rnd%0d_cur_m", t), 32'(bus.alu_cur_m), 32'(md_m[ars]));
      chk($sformatf("rnd%0d_cur_n", t), 32'(bus.alu_cur_n), 32'(md_n[ars]));
      idle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
